// File: rtl/sram64x8_req_ctrl.sv
// sram64x8_req_ctrl
//   Request/response front end for the 64x8 single-port SRAM macro. Turns a
//   valid/ready read/write request stream into the macro's active-low
//   CSB/WEB/OEB strobes, and buffers read data in a small response FIFO so
//   downstream backpressure never drops a read. The macro clock pin is tied
//   to clk outside this block.
//
//   Ports:
//     clk, reset            clock; asynchronous active-high reset
//     req_valid/req_ready   request handshake (reads and writes)
//     req_write             1 = write, 0 = read
//     req_addr, req_wdata   word address and write data
//     resp_valid/resp_ready read response handshake
//     resp_rdata            read data, returned in request order
//     sram_a, sram_i        macro address / write data pins
//     sram_o                macro read data (valid the cycle after a read)
//     sram_csb/web/oeb      macro strobes, active low
//
//   Optional build macro SRAM_CTRL_INIT_EN: after reset, sweep all 64 words
//   writing zero before accepting requests.

module sram64x8_req_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int RESP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESP_DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    INIT = 1'b1
  } state_t;

`ifdef SRAM_CTRL_INIT_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  state_t state, state_next;

  logic              rd_inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  occupancy;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_inc;
  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
  logic [DATA_W-1:0] head;
  logic              fire, read_fire, push, pop;

`ifdef SRAM_CTRL_INIT_EN
  logic [ADDR_W-1:0] init_ptr;
`endif

  // Credit check counts the read still in the macro pipeline as well as the
  // queued data, so a push can never find the FIFO full. A pop in the same
  // cycle is deliberately not credited. Gated by reset so no request is
  // accepted while reset is held.
  assign occupancy  = fifo_count + CNT_W'(rd_inflight);
  assign req_ready  = ~reset & (state == RUN) & (occupancy < DEPTH_C);
  assign fire       = req_valid & req_ready;
  assign read_fire  = fire & ~req_write;
  assign push       = rd_inflight;
  assign resp_valid = (fifo_count != '0);
  assign pop        = resp_valid & resp_ready;
  assign resp_rdata = head;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
`ifdef SRAM_CTRL_INIT_EN
    if ((state == INIT) && (&init_ptr)) begin
      state_next = RUN;
    end
`endif
  end

  // Macro pins follow the current request combinationally so the macro
  // samples the request on the edge that ends the fire cycle.
  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_oeb = 1'b1;
    sram_a   = req_addr;
    sram_i   = req_wdata;
    if (fire) begin
      sram_csb = 1'b0;
      if (req_write) begin
        sram_web = 1'b0;
      end else begin
        sram_oeb = 1'b0;
      end
    end
`ifdef SRAM_CTRL_INIT_EN
    if (state == INIT) begin
      sram_a = init_ptr;
      sram_i = '0;
      if (!reset) begin
        sram_csb = 1'b0;
        sram_web = 1'b0;
      end
    end
`endif
  end

`ifdef SRAM_CTRL_INIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_ptr <= '0;
    end else if (state == INIT) begin
      init_ptr <= init_ptr + ADDR_W'(1);
    end
  end
`endif

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sram_o;
    end
  end

  // head is the registered front of the FIFO. When the FIFO is empty or
  // about to drain to its last entry it takes the incoming macro data
  // directly; otherwise it advances to the next stored entry on a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_inflight <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      head        <= '0;
    end else begin
      rd_inflight <= read_fire;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (fifo_count == '0) begin
        if (push) begin
          head <= sram_o;
        end
      end else if (pop) begin
        if (fifo_count > CNT_W'(1)) begin
          head <= fifo_mem[rd_ptr_inc];
        end else if (push) begin
          head <= sram_o;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram64x8_req_ctrl.sv
// tb_sram64x8_req_ctrl
//   Directed testbench for sram64x8_req_ctrl with a behavioural 64x8 SRAM
//   macro model attached to the sram_* pins. Inputs change and outputs are
//   sampled at the falling clock edge.

module tb_sram64x8_req_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_rdata;
  logic [5:0] sram_a;
  logic [7:0] sram_i;
  logic [7:0] sram_o;
  logic       sram_csb;
  logic       sram_web;
  logic       sram_oeb;

  int num_checks = 0;
  int num_fails  = 0;

  logic [7:0] macro_mem [64];

  sram64x8_req_ctrl #(
    .ADDR_W(6),
    .DATA_W(8),
    .RESP_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .sram_a(sram_a),
    .sram_i(sram_i),
    .sram_o(sram_o),
    .sram_csb(sram_csb),
    .sram_web(sram_web),
    .sram_oeb(sram_oeb)
  );

  always #5 clk = ~clk;

  // Behavioural macro: synchronous write, read data appears after the edge.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        macro_mem[sram_a] <= sram_i;
      end else if (!sram_oeb) begin
        sram_o <= macro_mem[sram_a];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic write,
                               input logic [5:0] addr, input logic [7:0] wdata);
    req_valid = valid;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic writeWord(input logic [5:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b1, addr, data);
    tick;
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  // Release reset at a falling edge; with the init sweep built in, check all
  // 64 zero-writes before the block starts accepting requests.
  task automatic releaseReset;
    reset = 1'b0;
`ifdef SRAM_CTRL_INIT_EN
    for (int i = 0; i < 64; i++) begin
      #1;
      checkOutput("init_strobes", {sram_csb, sram_web, sram_oeb}, 3'b001);
      checkOutput("init_addr", sram_a, i);
      checkOutput("init_data", sram_i, 0);
      checkOutput("init_ready", req_ready, 0);
      tick;
    end
`endif
    #1;
    checkOutput("ready_after_reset", req_ready, 1);
  endtask

  // Issues n_req reads from base upwards and collects n_resp responses whose
  // data are dbase, dbase+1, ... in order; optionally checks that every read
  // is accepted at once and answered exactly two cycles later.
  task automatic pumpReads(input int n_req, input logic [5:0] base, input int n_resp,
                           input logic [7:0] dbase, input bit check_lat);
    int issued = 0;
    int got    = 0;
    int cyc    = 0;
    int fire_cyc[$];
    while ((issued < n_req || got < n_resp) && cyc < 60) begin
      applyStimulus(issued < n_req, 1'b0, 6'(base + issued), 8'd0);
      #1;
      if (check_lat && issued < n_req) checkOutput("b2b_ready", req_ready, 1);
      if (resp_valid && resp_ready) begin
        checkOutput("rd_data", resp_rdata, 8'(dbase + got));
        if (check_lat && got < fire_cyc.size()) checkOutput("rd_latency", cyc - fire_cyc[got], 2);
        got++;
      end
      if (req_valid && req_ready) begin
        fire_cyc.push_back(cyc);
        issued++;
      end
      tick;
      cyc++;
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    checkOutput("resp_count", got, n_resp);
    checkOutput("issue_count", issued, n_req);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) macro_mem[i] = 8'($urandom);
    sram_o     = 8'h00;
    reset      = 1'b1;
    resp_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);

    // Reset state
    tick;
    req_valid = 1'b1;
    #1;
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_resp_rdata", resp_rdata, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_strobes", {sram_csb, sram_web, sram_oeb}, 3'b111);
    tick;
    req_valid = 1'b0;
    releaseReset;

    // Idle cycles leave all strobes high
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("idle_strobes", {sram_csb, sram_web, sram_oeb}, 3'b111);
      tick;
    end

    // Write 0xA5 to 0x03 then read it back the next cycle
    applyStimulus(1'b1, 1'b1, 6'h03, 8'hA5);
    #1;
    checkOutput("wr_strobes", {sram_csb, sram_web, sram_oeb}, 3'b001);
    checkOutput("wr_addr", sram_a, 6'h03);
    checkOutput("wr_data", sram_i, 8'hA5);
    tick;
    applyStimulus(1'b1, 1'b0, 6'h03, 8'h00);
    #1;
    checkOutput("rd_strobes", {sram_csb, sram_web, sram_oeb}, 3'b010);
    checkOutput("rd_addr", sram_a, 6'h03);
    tick;
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    #1;
    checkOutput("rd_t1_valid", resp_valid, 0);
    tick;
    #1;
    checkOutput("rd_t2_valid", resp_valid, 1);
    checkOutput("rd_t2_data", resp_rdata, 8'hA5);
    tick;
    #1;
    checkOutput("drained_valid", resp_valid, 0);
    checkOutput("rdata_hold", resp_rdata, 8'hA5);

    // Credit limit with resp_ready low, then drain in order
    for (int i = 0; i < 6; i++) writeWord(6'(i), 8'(8'h10 + i));
    resp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, (i < 4) ? 6'(i) : 6'd4, 8'd0);
      #1;
      checkOutput("credit_ready", req_ready, (i < 4) ? 1 : 0);
      tick;
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    #1;
    checkOutput("stall_valid", resp_valid, 1);
    checkOutput("stall_head", resp_rdata, 8'h10);
    checkOutput("stall_ready", req_ready, 0);
    resp_ready = 1'b1;
    pumpReads(2, 6'd4, 6, 8'h10, 1'b0);

    // Back-to-back reads with resp_ready high
    for (int i = 0; i < 8; i++) writeWord(6'(6'h20 + i), 8'(8'hC0 + i));
    pumpReads(8, 6'h20, 8, 8'hC0, 1'b1);

`ifdef SRAM_CTRL_INIT_EN
    // After the init sweep, untouched words read as zero
    pumpReads(1, 6'h2A, 1, 8'h00, 1'b1);
`endif

    // Reset with 3 responses queued and 1 read in flight
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 6'(i), 8'd0);
      tick;
    end
    applyStimulus(1'b1, 1'b0, 6'd4, 8'd0);
    #1;
    checkOutput("pre_rst_valid", resp_valid, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", resp_valid, 0);
    checkOutput("mid_rst_strobes", {sram_csb, sram_web, sram_oeb}, 3'b111);
    checkOutput("mid_rst_ready", req_ready, 0);
    tick;
    applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
    resp_ready = 1'b1;
    releaseReset;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput("no_stale_valid", resp_valid, 0);
      tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/sram64x8_req_ctrl.md
Name: sram64x8_req_ctrl

Overview:
- Request/response front end that sits directly upstream of the 64x8 single-port SRAM macro and drives its pins.
- Converts a valid/ready request stream (read or write) into the macro's active-low CSB/WEB/OEB strobes.
- Captures read data from the macro's output into a response FIFO so that downstream backpressure never loses read data.
- Macro clock pin is tied to clk outside this block.

Parameters:
- ADDR_W, 6, SRAM address width (64 words)
- DATA_W, 8, SRAM word width
- RESP_DEPTH, 4, response FIFO entries; power of two, >=2

Ports:
- clk  input  1  clock; also drives macro CE
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- resp_valid  output  1  read data available
- resp_ready  input  1  downstream accepts read data
- resp_rdata  output  DATA_W  read data, in request order
- sram_a  output  ADDR_W  to macro A
- sram_i  output  DATA_W  to macro I
- sram_o  input  DATA_W  from macro O
- sram_csb  output  1  to macro CSB, active low
- sram_web  output  1  to macro WEB, active low
- sram_oeb  output  1  to macro OEB, active low

Behaviour:
- Reset (async, active-high):
  - FIFO empty, rd_inflight=0, state=RUN (or INIT, see Optional Feature).
  - Outputs during and after reset: resp_valid=0, resp_rdata=0, req_ready=0 while reset is high, sram_csb=sram_web=sram_oeb=1.
- req_ready = (state==RUN) & (rd_inflight + fifo_count < RESP_DEPTH).
  - Same-cycle pop is not credited (conservative).
  - req_ready applies to writes as well, and never depends on req_valid.
- fire = req_valid & req_ready.
- Pin drive is combinational from the current request:
  - sram_a = req_addr and sram_i = req_wdata in RUN.
  - Write fire: csb=0, web=0, oeb=1.
  - Read fire: csb=0, oeb=0, web=1.
  - No fire: csb=web=oeb=1.
- The macro samples on the rising edge that ends the fire cycle t.
- Read pipeline:
  - rd_inflight is set at the end of cycle t; sram_o is valid during t+1.
  - sram_o is pushed into the FIFO at the end of t+1; rd_inflight clears unless another read fired in t+1.
  - resp_valid is first high in t+2. Read latency = 2 cycles.
- FIFO:
  - Registered head drives resp_rdata; pop = resp_valid & resp_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Read/write pointers wrap mod RESP_DEPTH.
  - Overflow is impossible by construction (credit check).
  - resp_rdata holds its last value when the FIFO is empty.
- Throughput:
  - One request per cycle is sustained with resp_ready=1 and RESP_DEPTH>=2.
  - With resp_ready=0, exactly RESP_DEPTH reads are accepted, then req_ready=0 until a pop.
- Ordering:
  - Write to X in cycle t followed by read of X in t+1 returns the new data.
  - Responses are returned strictly in request order.
  - Writes produce no response.
- Reset mid-operation:
  - Queued and in-flight reads are discarded.
  - resp_valid drops immediately; sram strobes go high immediately.

Optional Feature:
- Macro: SRAM_CTRL_INIT_EN
- With the macro defined:
  - Reset enters state INIT; req_ready=0.
  - Each cycle drives csb=0, web=0, oeb=1, sram_a=init_ptr, sram_i=0, then increments init_ptr from 0 to 63.
  - After writing address 63, the block moves to RUN on the next edge, so req_ready rises in the 65th cycle after reset deassert.
  - Reset during INIT restarts INIT at init_ptr=0.
- Without the macro:
  - Reset enters RUN directly; req_ready=1 in the first cycle after reset deassert.
  - Memory contents remain random.

Test Plan:
- Write 0xA5 to addr 0x03, then read addr 0x03 in the next cycle -> strobes csb=0/web=0, then csb=0/oeb=0; resp_valid high 2 cycles after the read fire with resp_rdata=0xA5.
- Hold resp_ready=0 and issue 6 reads of addrs 0..5 (pre-written 0x10..0x15) -> exactly 4 accepted, req_ready=0 afterwards; raise resp_ready -> data 0x10,0x11,0x12,0x13 in order, then the remaining 2 reads are accepted and return 0x14,0x15.
- Back-to-back reads every cycle with resp_ready=1 -> req_ready stays 1, one response per cycle, each 2 cycles after its request.
- Assert reset while 3 responses are queued and 1 is in flight -> resp_valid=0 at once, strobes=1; after release, no stale response ever appears.
- Idle with req_valid=0 -> csb=web=oeb=1 every cycle.
- With SRAM_CTRL_INIT_EN, after reset -> 64 write strobes at addrs 0..63 with data 0; req_ready rises in the 65th cycle; reading addr 0x2A then returns 0x00.
